// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write bus of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: LEN_HI LEN_LO payload CSUM frame into IM, holds CPU until verified
// Optional idle timeout under IMEM_LOADER_TIMEOUT_EN (TIMEOUT_CYC exists only in that build).
module imem_loader #(
  parameter int ADDR_W = 10
`ifdef IMEM_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1000
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] words_loaded
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_W;

  state_t      state;
  logic [15:0] len;
  logic [23:0] word;
  logic [1:0]  byte_cnt;
  logic [7:0]  csum;

  logic            accept;
  logic [15:0]     n_len;
  logic [ADDR_W:0] wl_next;

  assign accept  = bus.in_valid & bus.in_ready;
  assign n_len   = {len[15:8], bus.in_data};
  assign wl_next = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      len          <= '0;
      word         <= '0;
      byte_cnt     <= '0;
      csum         <= '0;
      bus.in_ready <= 1'b0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
      idle_cnt     <= '0;
`endif
    end else begin
      bus.im_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state        <= S_LEN_HI;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= '0;
            csum         <= '0;
            byte_cnt     <= '0;
`ifdef IMEM_LOADER_TIMEOUT_EN
            idle_cnt     <= '0;
`endif
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len[15:8] <= bus.in_data;
            state     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= bus.in_data;
            if (32'(n_len) > MAX_WORDS) begin
              state        <= S_ERROR;
              bus.in_ready <= 1'b0;
              busy         <= 1'b0;
              error        <= 1'b1;
            end else if (n_len == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word     <= {word[15:0], bus.in_data};
            csum     <= csum ^ bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.im_we    <= 1'b1;
              bus.im_addr  <= words_loaded[ADDR_W-1:0];
              bus.im_wdata <= {word, bus.in_data};
              words_loaded <= wl_next;
              // in_ready stays high so a CSUM byte can land in the write cycle
              if (32'(wl_next) == 32'(len))
                state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
      if (state inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM}) begin
        if (accept) begin
          idle_cnt <= '0;
        end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC)) begin
          // no write for the partial word: the data branch only writes on an accepted 4th byte
          state        <= S_ERROR;
          bus.in_ready <= 1'b0;
          busy         <= 1'b0;
          error        <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - table-driven per-cycle vectors plus reset, full-fill and stall sequences
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam logic [31:0] W0 = 32'h20080005;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        vl;
    logic [7:0]  d;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];
  int n_vec = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  always @(negedge clk) begin
    if (bus.im_we) begin
      wr_addr.push_back(bus.im_addr);
      wr_data.push_back(bus.im_wdata);
    end
  end

  function automatic logic [63:0] pk(input logic rdy, input logic we, input logic [9:0] addr,
                                     input logic [31:0] wd, input logic b, input logic dn,
                                     input logic e, input logic h, input logic [10:0] wl);
    return {5'd0, rdy, we, addr, wd, b, dn, e, h, wl};
  endfunction

  function automatic logic [63:0] obs();
    return pk(bus.in_ready, bus.im_we, bus.im_addr, bus.im_wdata, busy, done, error, cpu_hold,
              words_loaded);
  endfunction

  function automatic vec_t v(input logic st, input logic vl, input logic [7:0] d,
                             input logic [63:0] exp);
    vec_t r;
    r.st = st; r.vl = vl; r.d = d; r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_bad++;
      $display("FAIL put_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_two_words(input logic [7:0] cs);
    logic [7:0] s [11];
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    s[10] = cs;
    pulse_start();
    for (int i = 0; i < 11; i++) put(s[i]);
    @(negedge clk);
  endtask

  logic [63:0] IDLE_O, RUN0, DONE2, ERR2;

  initial begin
    logic [31:0] w;
    logic [7:0]  cs;
    int          seq_bad;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    IDLE_O = pk(0, 0, 10'd0, 32'd0, 0, 0, 0, 1, 11'd0);
    RUN0   = pk(1, 0, 10'd0, 32'd0, 1, 0, 0, 1, 11'd0);
    DONE2  = pk(0, 0, 10'd1, 32'd0, 0, 1, 0, 0, 11'd2);
    ERR2   = pk(0, 0, 10'd1, 32'd0, 0, 0, 1, 1, 11'd2);

    // two-word load with a start pulse while busy, then a stray byte in DONE
    vecs.push_back(v(1, 0, 8'h00, IDLE_O));
    vecs.push_back(v(0, 1, 8'h00, RUN0));
    vecs.push_back(v(0, 1, 8'h02, RUN0));
    vecs.push_back(v(0, 1, 8'h20, RUN0));
    vecs.push_back(v(0, 1, 8'h08, RUN0));
    vecs.push_back(v(0, 1, 8'h00, RUN0));
    vecs.push_back(v(0, 1, 8'h05, RUN0));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 1, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(1, 1, 8'h00, pk(1, 0, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h2D, pk(1, 1, 10'd1, 32'd0, 1, 0, 0, 1, 11'd2)));
    vecs.push_back(v(0, 0, 8'h00, DONE2));
    vecs.push_back(v(0, 1, 8'h55, DONE2));
    vecs.push_back(v(0, 0, 8'h00, DONE2));
    // same stream with a bad checksum
    vecs.push_back(v(1, 0, 8'h00, DONE2));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h02, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h20, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h08, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h05, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 1, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd0, W0, 1, 0, 0, 1, 11'd1)));
    vecs.push_back(v(0, 1, 8'h2C, pk(1, 1, 10'd1, 32'd0, 1, 0, 0, 1, 11'd2)));
    vecs.push_back(v(0, 0, 8'h00, ERR2));
    // empty image
    vecs.push_back(v(1, 0, 8'h00, ERR2));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h00, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 0, 8'h00, pk(0, 0, 10'd1, 32'd0, 0, 1, 0, 0, 11'd0)));
    // oversize length 0x0401
    vecs.push_back(v(1, 0, 8'h00, pk(0, 0, 10'd1, 32'd0, 0, 1, 0, 0, 11'd0)));
    vecs.push_back(v(0, 1, 8'h04, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h01, pk(1, 0, 10'd1, 32'd0, 1, 0, 0, 1, 11'd0)));
    vecs.push_back(v(0, 1, 8'h00, pk(0, 0, 10'd1, 32'd0, 0, 0, 1, 1, 11'd0)));
    vecs.push_back(v(0, 0, 8'h00, pk(0, 0, 10'd1, 32'd0, 0, 0, 1, 1, 11'd0)));

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
      start        = vecs[i].st;
      bus.in_valid = vecs[i].vl;
      bus.in_data  = vecs[i].d;
      @(negedge clk);
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;

    // throttled input, reset after the 6th payload byte
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    put(8'h00);
    put(8'h02);
    foreach (W0[i]) begin end
    begin
      logic [7:0] p [6];
      p = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00};
      for (int i = 0; i < 6; i++) begin
        put(p[i]);
        @(negedge clk);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("reset_mid_data", obs(), IDLE_O);
    chk("reset_writes", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() == 1) chk("reset_word", {22'd0, wr_addr[0], wr_data[0]}, {22'd0, 10'd0, W0});
    wr_addr.delete();
    wr_data.delete();
    load_two_words(8'h2D);
    chk("reload_done", obs(), DONE2);
    chk("reload_writes", 64'(wr_addr.size()), 64'd2);
    if (wr_addr.size() == 2)
      chk("reload_w1", {22'd0, wr_addr[1], wr_data[1]}, {22'd0, 10'd1, 32'd0});

    // exact fill of 2^ADDR_W words
    wr_addr.delete();
    wr_data.delete();
    cs = 8'h00;
    pulse_start();
    put(8'h04);
    put(8'h00);
    for (int i = 0; i < 1024; i++) begin
      w = {i[7:0] ^ 8'hA5, 8'h3C, i[15:8], i[7:0]};
      for (int b = 3; b >= 0; b--) begin
        cs ^= w[b*8 +: 8];
        put(w[b*8 +: 8]);
      end
    end
    put(cs);
    @(negedge clk);
    chk("fill_done", obs(), pk(0, 0, 10'd1023, w, 0, 1, 0, 0, 11'd1024));
    chk("fill_writes", 64'(wr_addr.size()), 64'd1024);
    seq_bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] != 10'(i) || wr_data[i] != {i[7:0] ^ 8'hA5, 8'h3C, i[15:8], i[7:0]})
        seq_bad++;
    end
    chk("fill_sequence", 64'(seq_bad), 64'd0);

    // stalled mid-word: no timeout in the default build
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    put(8'h00);
    put(8'h01);
    put(8'h20);
    repeat (20) @(negedge clk);
`ifndef IMEM_LOADER_TIMEOUT_EN
    chk("stall_busy", obs(), pk(1, 0, 10'd1023, w, 1, 0, 0, 1, 11'd0));
`endif
    chk("stall_no_write", 64'(wr_addr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
